// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared pipeline definitions: datapath width, branch funct3 codes,
// branch-controller state type and alignment helpers.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bits of the low target address that must be zero; 2'b10 means 4-byte
  // instruction alignment (bit 0 is always cleared or zero for branches).
  localparam logic [1:0] IALIGN_MASK = 2'b10;

  typedef enum logic {
    BR_IDLE,
    BR_REDIR
  } br_state_e;

  // Target is misaligned when any masked low address bit is set.
  function automatic logic misaligned(input logic [1:0] addr_lo,
                                      input logic [1:0] mask);
    return |(addr_lo & mask);
  endfunction

  // funct3 values 010 and 011 are not branch conditions.
  function automatic logic valid_branch_f3(input logic [2:0] funct3);
    return funct3[2] | ~funct3[1];
  endfunction

endpackage

// File: rtl/branch_cond.sv
`timescale 1ns/1ps
// Combinational branch condition evaluation for conditional branches.
module branch_cond #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            cond
);
  import cpu_pkg::*;

  // Select comparison by funct3; reserved encodings evaluate not-taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (rs1 == rs2);
      F3_BNE:  cond = (rs1 != rs2);
      F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: cond = (rs1 <  rs2);
      F3_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
`timescale 1ns/1ps
// EX-stage branch resolution: predict-not-taken, squash and redirect on
// taken control transfers, misaligned-target exceptions, perf counters.
module branch_ctrl #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             exc_valid,
  output logic [XLEN-1:0]  exc_tval,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] CLR_LSB = {{(XLEN-1){1'b1}}, 1'b0};

  br_state_e       state, next_state;
  logic            cond;
  logic            is_jalr, is_jal, is_branch;
  logic            resolve, taken, mis;
  logic [XLEN-1:0] jalr_sum, target;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .rs1    (ex_rs1_data),
    .rs2    (ex_rs2_data),
    .funct3 (ex_funct3),
    .cond   (cond)
  );

  // Type priority: jalr, then jal, then conditional branch.
  assign is_jalr   = ex_jalr;
  assign is_jal    = ~ex_jalr & ex_jal;
  assign is_branch = ~ex_jalr & ~ex_jal & ex_branch;

  assign jalr_sum = ex_rs1_data + ex_imm;
  assign target   = is_jalr ? (jalr_sum & CLR_LSB) : (ex_pc + ex_imm);
  assign taken    = is_jalr | is_jal | (is_branch & cond);
  assign mis      = misaligned(target[1:0], IALIGN_MASK);
  assign resolve  = (state == BR_IDLE) & ex_valid & ~ex_stall
                  & (ex_branch | ex_jal | ex_jalr);

  // The redirect is outstanding exactly while the FSM waits in REDIR.
  assign redirect_valid = (state == BR_REDIR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BR_IDLE;
    else        state <= next_state;
  end

  // Next-state and flush: flush on a taken resolve and throughout REDIR.
  always_comb begin
    next_state = state;
    flush      = 1'b0;
    case (state)
      BR_IDLE: begin
        if (resolve && taken) begin
          flush = 1'b1;
          if (!mis) next_state = BR_REDIR;
        end
      end
      BR_REDIR: begin
        flush = 1'b1;
        if (redirect_ready) next_state = BR_IDLE;
      end
      default: next_state = BR_IDLE;
    endcase
  end

  // Capture redirect target on an aligned taken resolve; held through REDIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        redirect_pc <= '0;
    else if (resolve && taken && !mis) redirect_pc <= target;
  end

  // One-cycle exception pulse with the offending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      exc_tval  <= '0;
    end else begin
      exc_valid <= resolve & taken & mis;
      if (resolve && taken && mis) exc_tval <= target;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_taken    <= '0;
    end else if (resolve) begin
      if (is_branch && valid_branch_f3(ex_funct3) && perf_branches != '1)
        perf_branches <= perf_branches + CNT_W'(1);
      if (taken && perf_taken != '1)
        perf_taken <= perf_taken + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for branch_ctrl: directed vectors, a behavioural
// reference model compared every cycle, and literal spot checks.
module tb_branch_ctrl;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b1;
  logic            ex_valid, ex_stall, ex_branch, ex_jal, ex_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_imm;
  logic            redirect_ready;

  logic            flush, redirect_valid, exc_valid;
  logic [XLEN-1:0] redirect_pc, exc_tval;
  logic [31:0]     perf_branches, perf_taken;

  logic            n_flush, n_redirect_valid, n_exc_valid;
  logic [XLEN-1:0] n_redirect_pc, n_exc_tval;
  logic [3:0]      n_perf_branches, n_perf_taken;

  branch_ctrl #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_valid(exc_valid), .exc_tval(exc_tval),
    .perf_branches(perf_branches), .perf_taken(perf_taken)
  );

  // Narrow-counter build to reach saturation in few vectors.
  branch_ctrl #(.XLEN(XLEN), .CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .flush(n_flush),
    .redirect_valid(n_redirect_valid), .redirect_pc(n_redirect_pc),
    .redirect_ready(redirect_ready), .exc_valid(n_exc_valid), .exc_tval(n_exc_tval),
    .perf_branches(n_perf_branches), .perf_taken(n_perf_taken)
  );

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_redir = 1'b0;
  logic [31:0] m_rpc   = '0;
  bit          m_exc   = 1'b0;
  logic [31:0] m_tval  = '0;
  longint      m_br    = 0;
  longint      m_tk    = 0;

  function automatic bit cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat(input longint c, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  function automatic void model_eval(output bit res, output bit tk,
                                     output bit cnt_br, output logic [31:0] tgt);
    res = !m_redir && ex_valid && !ex_stall && (ex_branch || ex_jal || ex_jalr);
    cnt_br = 1'b0;
    if (ex_jalr) begin
      tk  = 1'b1;
      tgt = (ex_rs1_data + ex_imm) & 32'hFFFF_FFFE;
    end else if (ex_jal) begin
      tk  = 1'b1;
      tgt = ex_pc + ex_imm;
    end else begin
      tk  = cond_of(ex_funct3, ex_rs1_data, ex_rs2_data);
      tgt = ex_pc + ex_imm;
      cnt_br = (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
    end
  endfunction

  // Model advances on each clock edge; reset is asynchronous.
  always @(posedge clk or negedge rst_n) begin
    bit res, tk, cb;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_redir = 1'b0; m_rpc = '0; m_exc = 1'b0; m_tval = '0; m_br = 0; m_tk = 0;
    end else begin
      model_eval(res, tk, cb, tgt);
      m_exc = 1'b0;
      if (m_redir) begin
        if (redirect_ready) m_redir = 1'b0;
      end else if (res) begin
        if (cb) m_br++;
        if (tk) begin
          m_tk++;
          if (tgt[1]) begin m_exc = 1'b1; m_tval = tgt; end
          else begin m_redir = 1'b1; m_rpc = tgt; end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit res, tk, cb, eflush;
    logic [31:0] tgt;
    if (chk_en) begin
      model_eval(res, tk, cb, tgt);
      eflush = m_redir || (res && tk);
      chk("flush", flush, eflush);
      chk("redirect_valid", redirect_valid, m_redir);
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("exc_valid", exc_valid, m_exc);
      if (m_exc) chk("exc_tval", exc_tval, m_tval);
      chk("perf_branches", perf_branches, sat(m_br, 32));
      chk("perf_taken", perf_taken, sat(m_tk, 32));
      chk("n_flush", n_flush, eflush);
      chk("n_redirect_valid", n_redirect_valid, m_redir);
      chk("n_perf_branches", n_perf_branches, sat(m_br, 4));
      chk("n_perf_taken", n_perf_taken, sat(m_tk, 4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
    ex_funct3 = 0; ex_rs1_data = 0; ex_rs2_data = 0; ex_pc = 0; ex_imm = 0;
  endtask

  task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] c,
                       input logic [31:0] pc, input logic [31:0] imm);
    ex_valid = 1; ex_stall = 0; ex_branch = b; ex_jal = j; ex_jalr = jr;
    ex_funct3 = f3; ex_rs1_data = a; ex_rs2_data = c; ex_pc = pc; ex_imm = imm;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [31:0] ops [7][2];

  initial begin
    ops = '{'{32'h0, 32'h0}, '{32'h1, 32'h0}, '{32'h0, 32'h1},
            '{32'h8000_0000, 32'h7FFF_FFFF}, '{32'h7FFF_FFFF, 32'h8000_0000},
            '{32'hFFFF_FFFF, 32'h0}, '{32'h0, 32'hFFFF_FFFF}};
    idle_in();
    redirect_ready = 0;
    #2 rst_n = 0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst redirect_valid", redirect_valid, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    chk("rst exc_valid", exc_valid, 0);
    chk("rst exc_tval", exc_tval, 0);
    chk("rst perf_branches", perf_branches, 0);
    chk("rst perf_taken", perf_taken, 0);
    cyc();
    rst_n = 1;

    // BLT signed: -1 < 1 taken
    redirect_ready = 1;
    drive(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    @(negedge clk); chk("blt flush", flush, 1);
    cyc(); idle_in();
    @(negedge clk); chk("blt rv", redirect_valid, 1); chk("blt rpc", redirect_pc, 32'h120);
    cyc();
    @(negedge clk); chk("blt rv drop", redirect_valid, 0);
    chk("blt br", perf_branches, 1); chk("blt tk", perf_taken, 1);

    // BLTU same operands: not taken
    cyc(); drive(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    @(negedge clk); chk("bltu flush", flush, 0);
    cyc(); idle_in();
    @(negedge clk); chk("bltu rv", redirect_valid, 0);
    chk("bltu br", perf_branches, 2); chk("bltu tk", perf_taken, 1);

    // JALR misaligned target
    cyc(); drive(0, 0, 1, 3'b000, 32'h1003, 32'h0, 32'h0, 32'h0);
    @(negedge clk); chk("jalr flush", flush, 1);
    cyc(); idle_in();
    @(negedge clk); chk("jalr exc", exc_valid, 1); chk("jalr tval", exc_tval, 32'h1002);
    chk("jalr rv", redirect_valid, 0); chk("jalr tk", perf_taken, 2);
    cyc();
    @(negedge clk); chk("jalr exc drop", exc_valid, 0);

    // JAL with fetch back-pressure for 3 cycles
    cyc(); redirect_ready = 0; drive(0, 1, 0, 3'b000, 0, 0, 32'h200, 32'h40);
    @(negedge clk); chk("jal flush", flush, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(0, 1, 0, 3'b000, 0, 0, 32'h800, 32'h4);
      @(negedge clk);
      chk("jal hold rv", redirect_valid, 1); chk("jal hold rpc", redirect_pc, 32'h240);
      chk("jal hold flush", flush, 1); chk("jal hold tk", perf_taken, 3);
    end
    cyc(); redirect_ready = 1;
    @(negedge clk); chk("jal ready rv", redirect_valid, 1);
    cyc(); idle_in();
    @(negedge clk); chk("jal exit rv", redirect_valid, 0); chk("jal exit tk", perf_taken, 3);

    // BEQ held by stall for 2 cycles
    cyc(); drive(1, 0, 0, 3'b000, 32'h5, 32'h5, 32'h300, 32'h10); ex_stall = 1;
    @(negedge clk); chk("stall flush0", flush, 0);
    cyc();
    @(negedge clk); chk("stall flush1", flush, 0); chk("stall br", perf_branches, 2);
    cyc(); ex_stall = 0;
    @(negedge clk); chk("unstall flush", flush, 1);
    cyc(); idle_in();
    @(negedge clk); chk("beq rv", redirect_valid, 1); chk("beq rpc", redirect_pc, 32'h310);
    chk("beq br", perf_branches, 3); chk("beq tk", perf_taken, 4);

    // Reserved funct3: not taken, not counted
    cyc(); drive(1, 0, 0, 3'b010, 32'h7, 32'h7, 32'h900, 32'h4);
    @(negedge clk); chk("rsv flush", flush, 0);
    cyc(); idle_in();
    @(negedge clk); chk("rsv br", perf_branches, 3); chk("rsv tk", perf_taken, 4);

    // Drive the 4-bit counters into saturation
    for (int k = 0; k < 14; k++) begin
      cyc(); drive(1, 0, 0, 3'b000, 32'h5, 32'h5, 32'h500, 32'h10);
      cyc(); idle_in();
    end
    cyc();
    @(negedge clk);
    chk("sat n_br", n_perf_branches, 4'hF); chk("sat n_tk", n_perf_taken, 4'hF);
    chk("sat br", perf_branches, 17); chk("sat tk", perf_taken, 18);

    // funct3 sweep over signed/unsigned corner operands
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 7; p++) begin
        cyc(); drive(1, 0, 0, 3'(f), ops[p][0], ops[p][1], 32'h400, 32'h8);
        cyc(); idle_in();
      end
    end

    // Asynchronous reset in the middle of a redirect
    cyc(); redirect_ready = 0; drive(0, 1, 0, 3'b000, 0, 0, 32'h600, 32'h8);
    cyc(); idle_in();
    @(negedge clk); chk("pre-rst rv", redirect_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid-rst rv", redirect_valid, 0); chk("mid-rst rpc", redirect_pc, 0);
    chk("mid-rst flush", flush, 0); chk("mid-rst br", perf_branches, 0);
    chk("mid-rst tk", perf_taken, 0); chk("mid-rst n_tk", n_perf_taken, 0);
    cyc(); rst_n = 1; redirect_ready = 1;
    drive(1, 0, 0, 3'b001, 32'h1, 32'h2, 32'h700, 32'h4);
    @(negedge clk); chk("post-rst flush", flush, 1);
    cyc(); idle_in();
    @(negedge clk); chk("post-rst rv", redirect_valid, 1); chk("post-rst rpc", redirect_pc, 32'h704);
    chk("post-rst br", perf_branches, 1);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
